pulse_decoder: RTL and testbench

Registered binary-to-one-hot decoder with a valid/ready input handshake. It converts a 2-bit priority code into a one-hot strobe on `out`, held for a programmable number of cycles, then signals completion. It sits downstream of the priority encoder and turns the encoded winner back into a per-line select/strobe for the requesting channel.

---
 rtl/pulse_decoder_if.sv | 33 +++
 rtl/pulse_decoder.sv | 163 ++++++++++++++++
 tb/tb_pulse_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_decoder_if.sv
// Handshake and strobe bundle between a code source and pulse_decoder.
// The source drives enable/in/in_valid; the decoder returns ready and the strobe outputs.
interface pulse_decoder_if #(
    parameter int WIDTH = 2
);
    logic                enable;
    logic [WIDTH-1:0]    in;
    logic                in_valid;
    logic                in_ready;
    logic [2**WIDTH-1:0] out;
    logic                busy;
    logic                done;

    modport master (
        output enable,
        output in,
        output in_valid,
        input  in_ready,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  in,
        input  in_valid,
        output in_ready,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/pulse_decoder.sv
// Registered binary-to-one-hot strobe generator with valid/ready intake and a done pulse.
// Optional feature macro PULSE_DEC_GAP_EN inserts a one-cycle GAP state between strobes.
module pulse_decoder #(
    parameter int WIDTH     = 2,
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pulse_decoder_if.slave bus
);
    localparam int               OUT_W    = 2**WIDTH;
    localparam int               LOAD_INT = (PULSE_LEN == 0) ? 0 : PULSE_LEN - 1;
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_INT);

`ifdef PULSE_DEC_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1
    } state_t;
`endif

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [OUT_W-1:0] out_r;
    logic [OUT_W-1:0] out_next_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             done_r;
    logic             done_next_s;
    logic             ready_s;
    logic             accept_s;
    logic             last_s;

    function automatic logic [OUT_W-1:0] onehot(input logic [WIDTH-1:0] code);
        logic [OUT_W-1:0] vec;
        vec       = {OUT_W{1'b0}};
        vec[code] = 1'b1;
        return vec;
    endfunction

    // Last active cycle of a strobe: counter exhausted and counting enabled.
    assign last_s   = (state_r == ST_DRIVE) && bus.enable && (cnt_r == {CNT_W{1'b0}});
    assign accept_s = bus.in_valid && ready_s;

    // Intake readiness; without the gap a new code may overlap the final strobe cycle.
    always_comb begin
        ready_s = 1'b0;
        if (rst_n && bus.enable) begin
`ifdef PULSE_DEC_GAP_EN
            ready_s = (state_r == ST_IDLE);
`else
            ready_s = (state_r == ST_IDLE) || last_s;
`endif
        end else begin
            ready_s = 1'b0;
        end
    end

    // State register together with the registered outputs and pulse counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            out_r   <= {OUT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            out_r   <= out_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_DRIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (last_s) begin
`ifdef PULSE_DEC_GAP_EN
                    state_next_s = ST_GAP;
`else
                    state_next_s = accept_s ? ST_DRIVE : ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_DRIVE;
                end
            end
`ifdef PULSE_DEC_GAP_EN
            ST_GAP: begin
                state_next_s = ST_IDLE;
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values for counter, strobe, busy and done.
    always_comb begin
        cnt_next_s  = cnt_r;
        out_next_s  = out_r;
        done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_next_s = LOAD_CNT;
                    out_next_s = onehot(bus.in);
                end else begin
                    cnt_next_s = {CNT_W{1'b0}};
                    out_next_s = {OUT_W{1'b0}};
                end
            end
            ST_DRIVE: begin
                if (!bus.enable) begin
                    cnt_next_s = cnt_r;
                    out_next_s = out_r;
                end else if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                    out_next_s = out_r;
                end else begin
                    done_next_s = 1'b1;
                    if (accept_s) begin
                        cnt_next_s = LOAD_CNT;
                        out_next_s = onehot(bus.in);
                    end else begin
                        cnt_next_s = {CNT_W{1'b0}};
                        out_next_s = {OUT_W{1'b0}};
                    end
                end
            end
            default: begin
                cnt_next_s = {CNT_W{1'b0}};
                out_next_s = {OUT_W{1'b0}};
            end
        endcase
        busy_next_s = (state_next_s == ST_DRIVE);
    end

    assign bus.in_ready = ready_s;
    assign bus.out      = out_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_pulse_decoder.sv
// Bench for pulse_decoder: two instances (PULSE_LEN 4 and 0) share stimulus and are
// compared each cycle against a strobe-remaining reference model.
module tb_pulse_decoder;
`ifdef PULSE_DEC_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_decoder_if #(.WIDTH(2)) bus_a ();
    pulse_decoder_if #(.WIDTH(2)) bus_b ();

    pulse_decoder #(.WIDTH(2), .PULSE_LEN(4), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    pulse_decoder #(.WIDTH(2), .PULSE_LEN(0), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int         plen [2] = '{4, 1};
    bit         m_act [2];
    bit         m_gap [2];
    bit         m_done [2];
    bit         m_acc [2];
    int         m_rem [2];
    logic [3:0] m_out [2];
    logic       exp_rdy [2];
    logic       obs_rdy [2];
    logic [6:0] obs_v [2];
    logic [6:0] exp_v [2];
    int         passes = 0;
    int         total  = 0;

    // One clock cycle: apply inputs, sample ready, advance the model, sample outputs.
    task automatic tick(input logic r, input logic en, input logic v, input logic [1:0] c);
        rst_n          = r;
        bus_a.enable   = en;
        bus_a.in_valid = v;
        bus_a.in       = c;
        bus_b.enable   = en;
        bus_b.in_valid = v;
        bus_b.in       = c;
        #1;
        obs_rdy[0] = bus_a.in_ready;
        obs_rdy[1] = bus_b.in_ready;
        for (int k = 0; k < 2; k++)
            exp_rdy[k] = r && en && (m_act[k] ? (!GAP && m_rem[k] == 1) : !m_gap[k]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_act[k] = 1'b0; m_gap[k] = 1'b0; m_rem[k] = 0;
                m_out[k] = 4'b0000; m_done[k] = 1'b0; m_acc[k] = 1'b0;
            end else begin
                m_acc[k]  = v && exp_rdy[k];
                m_done[k] = 1'b0;
                if (m_gap[k]) begin
                    m_gap[k] = 1'b0;
                end else if (m_act[k]) begin
                    if (en) begin
                        if (m_rem[k] > 1) begin
                            m_rem[k] = m_rem[k] - 1;
                        end else begin
                            m_done[k] = 1'b1;
                            if (m_acc[k]) begin
                                m_rem[k] = plen[k];
                                m_out[k] = 4'b0001 << c;
                            end else begin
                                m_act[k] = 1'b0;
                                m_out[k] = 4'b0000;
                                m_gap[k] = GAP;
                            end
                        end
                    end
                end else if (m_acc[k]) begin
                    m_act[k] = 1'b1;
                    m_rem[k] = plen[k];
                    m_out[k] = 4'b0001 << c;
                end
            end
        end
        @(negedge clk);
        obs_v[0] = {obs_rdy[0], bus_a.busy, bus_a.done, bus_a.out};
        obs_v[1] = {obs_rdy[1], bus_b.busy, bus_b.done, bus_b.out};
        for (int k = 0; k < 2; k++)
            exp_v[k] = {exp_rdy[k], m_act[k], m_done[k], m_out[k]};
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b1, 2'b11);
        tick(1'b0, 1'b1, 1'b1, 2'b11);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v[k] !== 7'b000_0000)
                $display("FAIL reset_state dut%0d got %b want %b", k, obs_v[k], 7'b000_0000);
            else passes++;
        end
        tick(1'b1, 1'b1, 1'b1, 2'b11);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v[k] !== 7'b110_1000)
                $display("FAIL reset_release_accept dut%0d got %b want %b", k, obs_v[k], 7'b110_1000);
            else passes++;
        end
    endtask

    task automatic test_strobe(input string name, input bit stall, input int want_hi, input int want_done);
        int hi [2];
        int dpos [2];
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 2'b00);
        hi   = '{0, 0};
        dpos = '{-1, -1};
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, !(stall && (i == 2 || i == 3)), i == 0, 2'b10);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v[k] !== exp_v[k])
                    $display("FAIL %s_cycle%0d dut%0d got %b want %b", name, i, k, obs_v[k], exp_v[k]);
                else passes++;
                if (obs_v[k][3:0] === 4'b0100) hi[k]++;
                if (obs_v[k][4] === 1'b1 && dpos[k] < 0) dpos[k] = i;
            end
        end
        total++;
        if (hi[0] != want_hi || dpos[0] != want_done)
            $display("FAIL %s_len4 got width %0d done@%0d want width %0d done@%0d", name, hi[0], dpos[0], want_hi, want_done);
        else passes++;
        total++;
        if (hi[1] != 1 || dpos[1] != 1)
            $display("FAIL %s_len0 got width %0d done@%0d want width 1 done@1", name, hi[1], dpos[1]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] hist [14];
        bit sent2;
        int n1, n3, first3, last1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 2'b00);
        sent2 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, 1'b1, (i == 0) || !sent2, (i == 0) ? 2'b01 : 2'b11);
            if (i > 0 && m_acc[0]) sent2 = 1'b1;
            hist[i] = bus_a.out;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v[k] !== exp_v[k])
                    $display("FAIL b2b_cycle%0d dut%0d got %b want %b", i, k, obs_v[k], exp_v[k]);
                else passes++;
            end
        end
        n1 = 0; n3 = 0; first3 = -1; last1 = -1;
        for (int i = 0; i < 14; i++) begin
            if (hist[i] === 4'b0010) begin n1++; last1 = i; end
            if (hist[i] === 4'b1000) begin n3++; if (first3 < 0) first3 = i; end
        end
        total++;
        if (n1 != 4 || n3 != 4 || (first3 - last1 - 1) != (GAP ? 2 : 0))
            $display("FAIL b2b_shape got %0d/%0d/%0d want 4/4/%0d", n1, n3, first3 - last1 - 1, GAP ? 2 : 0);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int dn;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b1, 2'b10);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 1'b0, 2'b00);
        total++;
        if (bus_a.out !== 4'b0000)
            $display("FAIL reset_mid_out got %b want %b", bus_a.out, 4'b0000);
        else passes++;
        dn = (bus_a.done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, 2'b00);
            if (bus_a.done !== 1'b0) dn++;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v[k] !== exp_v[k])
                    $display("FAIL reset_mid_cycle%0d dut%0d got %b want %b", i, k, obs_v[k], exp_v[k]);
                else passes++;
            end
        end
        total++;
        if (dn != 0)
            $display("FAIL reset_mid_done got %0d pulses want 0", dn);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)));
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v[k] !== exp_v[k])
                    $display("FAIL random_cycle%0d dut%0d got %b want %b", i, k, obs_v[k], exp_v[k]);
                else passes++;
            end
        end
    endtask

    initial begin
        bus_a.enable = 1'b0; bus_a.in_valid = 1'b0; bus_a.in = 2'b00;
        bus_b.enable = 1'b0; bus_b.in_valid = 1'b0; bus_b.in = 2'b00;
        @(negedge clk);
        test_reset();
        test_strobe("latency", 1'b0, 4, 4);
        test_strobe("enable_stall", 1'b1, 6, 6);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
